tcomp_serial_sched: RTL and testbench

- Round-robin scheduler and sequencer that shares one bit-serial two's-complement stage between two parallel requesters.
- Grants one requester, latches its WIDTH-bit word, clears the serial stage, and shifts the word through the stage LSB-first.
- Reassembles the serial output into a parallel result and returns it with the requester id over a valid/ready handshake.
- Sits between word-level clients and the serial complement datapath.

---
 rtl/tcomp_serial_sched_pkg.sv | 20 ++
 rtl/tcomp_serial_sched_if.sv | 27 ++
 rtl/tcomp_serial_stage.sv | 30 +++
 rtl/tcomp_serial_sched.sv | 109 ++++++++++
 tb/tb_tcomp_serial_sched.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/tcomp_serial_sched_pkg.sv
// rtl/tcomp_serial_sched_pkg.sv - shared types and helpers for the serial complement scheduler
package tcomp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        OUT
    } state_t;

    localparam logic REQ_ID_0 = 1'b0;
    localparam logic REQ_ID_1 = 1'b1;

    // Word is zero-extended by the caller; true only for 1 followed by width-1 zeros.
    function automatic logic is_most_neg(input logic [31:0] word, input int width);
        return word == (32'd1 << (width - 1));
    endfunction

endpackage

// File: rtl/tcomp_serial_sched_if.sv
// rtl/tcomp_serial_sched_if.sv - requester/result handshake bundle for the serial complement scheduler
interface tcomp_serial_sched_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_id;
    logic             out_ovf;
    logic             out_ready;
    logic             busy;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
        output req0_ready, req1_ready, out_valid, out_data, out_id, out_ovf, busy
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, out_ready,
        input  req0_ready, req1_ready, out_valid, out_data, out_id, out_ovf, busy
    );
endinterface

// File: rtl/tcomp_serial_stage.sv
// rtl/tcomp_serial_stage.sv - two-phase bit-serial two's complementer, LSB first, 1-cycle latency
module tcomp_serial_stage (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic din,
    output logic dout
);
    logic r_phase;
    logic r_dout;

    // Bits pass unchanged up to and including the first 1, then are inverted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase <= 1'b0;
            r_dout  <= 1'b0;
        end else if (clr) begin
            r_phase <= 1'b0;
            r_dout  <= 1'b0;
        end else begin
            r_dout <= din ^ r_phase;
            if (din) begin
                r_phase <= 1'b1;
            end
        end
    end

    assign dout = r_dout;

endmodule

// File: rtl/tcomp_serial_sched.sv
// rtl/tcomp_serial_sched.sv - round-robin scheduler sharing one serial complement stage between two requesters
module tcomp_serial_sched
    import tcomp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    tcomp_serial_sched_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    logic             r_rr_ptr;
    logic [WIDTH-1:0] r_in_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic [CW-1:0]    r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_id;
    logic             r_out_ovf;

    logic             w_idle;
    logic             w_acc0;
    logic             w_acc1;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_clr;
    logic             w_dout;

    // rr_ptr only breaks ties; a lone valid requester is always served.
    assign w_idle     = (r_state == IDLE);
    assign w_acc0     = w_idle & bus.req0_valid & ~(bus.req1_valid & r_rr_ptr);
    assign w_acc1     = w_idle & bus.req1_valid & ~(bus.req0_valid & ~r_rr_ptr);
    assign w_sel_data = w_acc1 ? bus.req1_data : bus.req0_data;
    assign w_clr      = (r_state == CLEAR);

    tcomp_serial_stage u_stage (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .din  (r_in_sr[0]),
        .dout (w_dout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= REQ_ID_0;
            r_in_sr     <= '0;
            r_res_sr    <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= REQ_ID_0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acc0 | w_acc1) begin
                        r_in_sr   <= w_sel_data;
                        r_out_id  <= w_acc1 ? REQ_ID_1 : REQ_ID_0;
                        r_rr_ptr  <= w_acc1 ? REQ_ID_0 : REQ_ID_1;
                        r_out_ovf <= is_most_neg(32'(w_sel_data), WIDTH);
                        r_state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_cnt   <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_in_sr <= r_in_sr >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                    // Stage output lags its input by one edge, so the first edge has nothing to capture.
                    if (r_cnt != '0) begin
                        r_res_sr <= {w_dout, r_res_sr[WIDTH-1:1]};
                    end
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_res_sr    <= {w_dout, r_res_sr[WIDTH-1:1]};
                    r_out_data  <= {w_dout, r_res_sr[WIDTH-1:1]};
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = w_acc0;
    assign bus.req1_ready = w_acc1;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_id     = r_out_id;
    assign bus.out_ovf    = r_out_ovf;
    assign bus.busy       = ~w_idle;

endmodule

// File: tb/tb_tcomp_serial_sched.sv
// tb/tb_tcomp_serial_sched.sv - self-checking bench for tcomp_serial_sched against a word-level model
module tb_tcomp_serial_sched;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tcomp_serial_sched_if #(.WIDTH(WIDTH)) bus ();

    tcomp_serial_sched #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int  n_checks = 0;
    int  n_errors = 0;
    int  m_rr     = 0;
    time last_acc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_tc(input int w);
        return 8'((256 - w) % 256);
    endfunction

    task automatic transact(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1,
                            input bit mutate, input int hold, input bit chk_period);
        int         g;
        int         lat;
        logic [7:0] w;
        logic [7:0] sd;
        logic       sid;
        @(negedge clk);
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
        bus.out_ready  = (hold == 0);
        g = (v0 && v1) ? m_rr : (v1 ? 1 : 0);
        w = (g == 1) ? d1 : d0;
        #1;
        check("ready_granted", (g == 1) ? bus.req1_ready : bus.req0_ready, 1);
        if (v0 && v1) check("ready_other", (g == 1) ? bus.req0_ready : bus.req1_ready, 0);
        @(posedge clk);
        if (chk_period) check("period", 32'((($time - last_acc) / 10)), WIDTH + 4);
        last_acc = $time;
        m_rr = 1 - g;
        lat  = 1;
        #1;
        if (g == 1) begin
            bus.req1_valid = 1'b0;
            if (mutate) bus.req1_data = ~d1;
        end else begin
            bus.req0_valid = 1'b0;
            if (mutate) bus.req0_data = ~d0;
        end
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("latency", lat, WIDTH + 3);
        check("out_data", bus.out_data, ref_tc(int'(w)));
        check("out_id", bus.out_id, g);
        check("out_ovf", bus.out_ovf, (w == 8'h80));
        if (hold > 0) begin
            sd  = bus.out_data;
            sid = bus.out_id;
            repeat (hold) begin
                @(negedge clk);
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, sd);
                check("hold_id", bus.out_id, sid);
                check("hold_ready0", bus.req0_ready, 0);
                check("hold_ready1", bus.req1_ready, 0);
            end
            @(negedge clk);
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("valid_drop", bus.out_valid, 0);
        check("busy_idle", bus.busy, 0);
    endtask

    initial begin
        bit         rv0;
        bit         rv1;
        logic [7:0] rd0;
        logic [7:0] rd1;
        bus.req0_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;
        bus.out_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_id", bus.out_id, 0);
        check("rst_ovf", bus.out_ovf, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ready0", bus.req0_ready, 0);
        check("rst_ready1", bus.req1_ready, 0);
        rst = 1'b1;

        transact(1, 8'h05, 0, 8'h00, 0, 0, 0);
        transact(0, 8'h00, 1, 8'h00, 0, 0, 0);
        transact(0, 8'h00, 1, 8'h80, 0, 0, 0);
        transact(0, 8'h00, 1, 8'hFF, 0, 0, 0);

        for (int i = 0; i < 4; i++) transact(1, 8'h01, 1, 8'h7F, 0, 0, i > 0);

        transact(1, 8'hAA, 1, 8'h55, 0, 20, 0);
        transact(1, 8'hAA, 1, 8'h55, 0, 0, 0);

        transact(1, 8'h3C, 0, 8'h00, 1, 0, 0);
        transact(0, 8'h00, 1, 8'h81, 1, 0, 0);

        for (int i = 0; i < 25; i++) begin
            rv0 = 1'($urandom_range(0, 1));
            rv1 = 1'($urandom_range(0, 1));
            if (!rv0 && !rv1) rv0 = 1'b1;
            rd0 = 8'($urandom);
            rd1 = 8'($urandom);
            if (i == 3) rd0 = 8'h80;
            transact(rv0, rd0, rv1, rd1, 1'($urandom_range(0, 1)), 0, 0);
        end

        transact(0, 8'h00, 1, 8'hFF, 0, 0, 0);
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h3C;
        bus.req1_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("busy_mid", bus.busy, 1);
        rst = 1'b0;
        #1;
        check("arst_valid", bus.out_valid, 0);
        check("arst_data", bus.out_data, 0);
        check("arst_id", bus.out_id, 0);
        check("arst_ovf", bus.out_ovf, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_ready0", bus.req0_ready, 0);
        check("arst_ready1", bus.req1_ready, 0);
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        m_rr = 0;
        transact(1, 8'h3C, 1, 8'h11, 0, 0, 0);
        transact(0, 8'h00, 1, 8'h11, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
